// File: rtl/decode_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe_stage_if
// Purpose  : Bundles the IF/ID inputs, control-unit word, writeback port,
//            redirect/stall controls and the ID/EX outputs of the decode
//            stage. The master side is the surrounding pipeline; the slave
//            side is decode_pipe_stage.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_pipe_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 24
);
    // Fetch side (IF/ID register contents)
    logic              if_valid;
    logic [15:0]       if_instr;
    logic [DATA_W-1:0] if_pc;
    // Control unit
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] dst_reg;
    logic              uses_rs;
    logic              uses_rt;
    logic              ctrl_err;
    // Writeback port
    logic              wb_wr_en;
    logic [REG_AW-1:0] wb_wr_reg;
    logic [DATA_W-1:0] wb_wr_data;
    // Pipeline control
    logic              flush;
    logic              stall_in;
    logic              id_stall;
    // ID/EX register
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rd_data_1;
    logic [DATA_W-1:0] ex_rd_data_2;
    logic [15:0]       ex_instr;
    logic [DATA_W-1:0] ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_AW-1:0] ex_dst_reg;
    logic              err;

    modport master (
        output if_valid, if_instr, if_pc, ctrl, dst_reg, uses_rs, uses_rt,
               ctrl_err, wb_wr_en, wb_wr_reg, wb_wr_data, flush, stall_in,
        input  id_stall, ex_valid, ex_rd_data_1, ex_rd_data_2, ex_instr,
               ex_pc, ex_ctrl, ex_dst_reg, err
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ctrl, dst_reg, uses_rs, uses_rt,
               ctrl_err, wb_wr_en, wb_wr_reg, wb_wr_data, flush, stall_in,
        output id_stall, ex_valid, ex_rd_data_1, ex_rd_data_2, ex_instr,
               ex_pc, ex_ctrl, ex_dst_reg, err
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe_stage
// Purpose  : Decode stage: register file with write-through bypass, load-use
//            hazard detection and the ID/EX pipeline register with stall,
//            flush and bubble insertion. Control decode lives outside; its
//            control word and destination register are registered here.
// Revision : 1.0 - initial release
// ============================================================================
module decode_pipe_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int CTRL_W   = 24,
    parameter int LOAD_BIT = 0,
    parameter int WREN_BIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    decode_pipe_stage_if.slave  bus
);
    localparam int NUM_REGS = 2 ** REG_AW;

    // Register file (register 0 is an ordinary, writable register)
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Source register fields
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [DATA_W-1:0] w_rd_data_1;
    logic [DATA_W-1:0] w_rd_data_2;
    logic              w_haz;
    logic              w_id_stall;

    // ID/EX register state and next state
    logic              ex_valid_q,     ex_valid_d;
    logic [DATA_W-1:0] ex_rd_data_1_q, ex_rd_data_1_d;
    logic [DATA_W-1:0] ex_rd_data_2_q, ex_rd_data_2_d;
    logic [15:0]       ex_instr_q,     ex_instr_d;
    logic [DATA_W-1:0] ex_pc_q,        ex_pc_d;
    logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
    logic [REG_AW-1:0] ex_dst_reg_q,   ex_dst_reg_d;
    logic              err_q,          err_d;

    assign w_rs = bus.if_instr[8 +: REG_AW];
    assign w_rt = bus.if_instr[5 +: REG_AW];

    // Combinational operand read; a same-cycle writeback to the read address wins
    always_comb begin
        w_rd_data_1 = regs_q[w_rs];
        w_rd_data_2 = regs_q[w_rt];
        if (bus.wb_wr_en && (bus.wb_wr_reg == w_rs)) begin
            w_rd_data_1 = bus.wb_wr_data;
        end
        if (bus.wb_wr_en && (bus.wb_wr_reg == w_rt)) begin
            w_rd_data_2 = bus.wb_wr_data;
        end
    end

    // Load-use hazard: a register-writing load in EX feeds a source of the instruction in ID
    always_comb begin
        w_haz = bus.if_valid & ex_valid_q
              & ex_ctrl_q[LOAD_BIT] & ex_ctrl_q[WREN_BIT]
              & ((bus.uses_rs & (w_rs == ex_dst_reg_q))
               | (bus.uses_rt & (w_rt == ex_dst_reg_q)));
        // A redirect discards the instruction in ID, so there is nothing to hold
        w_id_stall = ~bus.flush & (bus.stall_in | w_haz);
    end

    // ID/EX next state: flush beats downstream stall, which beats bubble insertion
    always_comb begin
        // Normal load; a bubble also loads the payload fields, only valid/ctrl are killed
        ex_valid_d     = bus.if_valid;
        ex_ctrl_d      = bus.if_valid ? bus.ctrl : '0;
        ex_rd_data_1_d = w_rd_data_1;
        ex_rd_data_2_d = w_rd_data_2;
        ex_instr_d     = bus.if_instr;
        ex_pc_d        = bus.if_pc;
        ex_dst_reg_d   = bus.dst_reg;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (bus.stall_in) begin
            ex_valid_d     = ex_valid_q;
            ex_ctrl_d      = ex_ctrl_q;
            ex_rd_data_1_d = ex_rd_data_1_q;
            ex_rd_data_2_d = ex_rd_data_2_q;
            ex_instr_d     = ex_instr_q;
            ex_pc_d        = ex_pc_q;
            ex_dst_reg_d   = ex_dst_reg_q;
        end else if (w_haz) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end
        // Illegal instruction is only recorded when it actually advances
        err_d = err_q | (bus.if_valid & bus.ctrl_err & ~bus.flush & ~w_id_stall);
    end

    // Register file write port; writes continue during stall and hazard cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_wr_en) begin
            regs_q[bus.wb_wr_reg] <= bus.wb_wr_data;
        end
    end

    // ID/EX pipeline register and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rd_data_1_q <= '0;
            ex_rd_data_2_q <= '0;
            ex_instr_q     <= '0;
            ex_pc_q        <= '0;
            ex_dst_reg_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rd_data_1_q <= ex_rd_data_1_d;
            ex_rd_data_2_q <= ex_rd_data_2_d;
            ex_instr_q     <= ex_instr_d;
            ex_pc_q        <= ex_pc_d;
            ex_dst_reg_q   <= ex_dst_reg_d;
            err_q          <= err_d;
        end
    end

    assign bus.id_stall     = w_id_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rd_data_1 = ex_rd_data_1_q;
    assign bus.ex_rd_data_2 = ex_rd_data_2_q;
    assign bus.ex_instr     = ex_instr_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_dst_reg   = ex_dst_reg_q;
    assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe_stage
// Purpose  : Self-checking bench for decode_pipe_stage. A driver applies one
//            stimulus vector per cycle and pushes the expected response from
//            a behavioural model; a monitor pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe_stage;

    typedef struct {
        logic        rst;
        logic        if_valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [23:0] ctrl;
        logic [2:0]  dst;
        logic        uses_rs;
        logic        uses_rt;
        logic        ctrl_err;
        logic        wb_en;
        logic [2:0]  wb_reg;
        logic [15:0] wb_data;
        logic        flush;
        logic        stall_in;
    } stim_t;

    typedef struct {
        bit          chk_stall;
        logic        stall;
        logic        valid;
        logic [23:0] ctrl;
        logic [2:0]  dst;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    // Behavioural model state: architectural registers plus what EX should hold
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [23:0] m_ctrl;
    logic [2:0]  m_dst;
    logic [15:0] m_instr, m_pc, m_rd1, m_rd2;
    logic        m_err;

    decode_pipe_stage_if #(.DATA_W(16), .REG_AW(3), .CTRL_W(24)) bus ();

    decode_pipe_stage #(
        .DATA_W(16), .REG_AW(3), .CTRL_W(24), .LOAD_BIT(0), .WREN_BIT(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Drive one cycle of stimulus and record what the stage must show afterwards
    task automatic apply(input stim_t s, input bit first);
        exp_t        e;
        logic [2:0]  rs, rt;
        logic        haz, stall;
        logic [15:0] rd1, rd2;
        @(negedge clk);
        rst              = s.rst;
        bus.if_valid     = s.if_valid;
        bus.if_instr     = s.instr;
        bus.if_pc        = s.pc;
        bus.ctrl         = s.ctrl;
        bus.dst_reg      = s.dst;
        bus.uses_rs      = s.uses_rs;
        bus.uses_rt      = s.uses_rt;
        bus.ctrl_err     = s.ctrl_err;
        bus.wb_wr_en     = s.wb_en;
        bus.wb_wr_reg    = s.wb_reg;
        bus.wb_wr_data   = s.wb_data;
        bus.flush        = s.flush;
        bus.stall_in     = s.stall_in;

        rs  = s.instr[10:8];
        rt  = s.instr[7:5];
        haz = s.if_valid && m_valid && m_ctrl[0] && m_ctrl[1] &&
              ((s.uses_rs && rs == m_dst) || (s.uses_rt && rt == m_dst));
        stall = !s.flush && (s.stall_in || haz);
        rd1 = (s.wb_en && s.wb_reg == rs) ? s.wb_data : m_regs[rs];
        rd2 = (s.wb_en && s.wb_reg == rt) ? s.wb_data : m_regs[rt];

        e.chk_stall = !first;
        e.stall     = stall;

        if (s.rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_valid = 0; m_ctrl = '0; m_dst = '0; m_instr = '0;
            m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_err = 0;
        end else begin
            if (s.if_valid && s.ctrl_err && !s.flush && !stall) m_err = 1'b1;
            if (!s.flush && s.stall_in) begin
                // held: nothing moves into EX
            end else begin
                m_dst = s.dst; m_instr = s.instr; m_pc = s.pc;
                m_rd1 = rd1;   m_rd2 = rd2;
                if (s.flush || haz) begin
                    m_valid = 1'b0;
                    m_ctrl  = '0;
                end else begin
                    m_valid = s.if_valid;
                    m_ctrl  = s.if_valid ? s.ctrl : 24'h0;
                end
            end
            if (s.wb_en) m_regs[s.wb_reg] = s.wb_data;
        end

        e.valid = m_valid; e.ctrl = m_ctrl; e.dst = m_dst; e.instr = m_instr;
        e.pc = m_pc; e.rd1 = m_rd1; e.rd2 = m_rd2; e.err = m_err;
        exp_q.push_back(e);
    endtask

    // Monitor: id_stall just before the edge, ID/EX contents just after it
    initial begin : monitor
        logic s_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            s_stall = bus.id_stall;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk_stall) chk("id_stall", {31'b0, s_stall}, {31'b0, e.stall});
                chk("ex_valid",     {31'b0, bus.ex_valid},     {31'b0, e.valid});
                chk("ex_ctrl",      {8'b0, bus.ex_ctrl},       {8'b0, e.ctrl});
                chk("ex_dst_reg",   {29'b0, bus.ex_dst_reg},   {29'b0, e.dst});
                chk("ex_instr",     {16'b0, bus.ex_instr},     {16'b0, e.instr});
                chk("ex_pc",        {16'b0, bus.ex_pc},        {16'b0, e.pc});
                chk("ex_rd_data_1", {16'b0, bus.ex_rd_data_1}, {16'b0, e.rd1});
                chk("ex_rd_data_2", {16'b0, bus.ex_rd_data_2}, {16'b0, e.rd2});
                chk("err",          {31'b0, bus.err},          {31'b0, e.err});
            end
        end
    end

    initial begin : driver
        stim_t s;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_valid = 0; m_ctrl = '0; m_dst = '0; m_instr = '0;
        m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_err = 0;
        rst = 1'b1;
        bus.if_valid = 0; bus.if_instr = '0; bus.if_pc = '0; bus.ctrl = '0;
        bus.dst_reg = '0; bus.uses_rs = 0; bus.uses_rt = 0; bus.ctrl_err = 0;
        bus.wb_wr_en = 0; bus.wb_wr_reg = '0; bus.wb_wr_data = '0;
        bus.flush = 0; bus.stall_in = 0;

        // Reset for two cycles, then read R5/R6 in the next instruction
        s = idle(); s.rst = 1;
        apply(s, 1'b1);
        apply(s, 1'b0);
        s = idle(); s.if_valid = 1; s.instr = 16'h05C0; s.uses_rs = 1; s.uses_rt = 1;
        s.ctrl = 24'h000002; s.pc = 16'h0002;
        apply(s, 1'b0);

        // Write-through bypass: R3 written while an ADD reads Rs=3, then a later read
        s = idle(); s.if_valid = 1; s.instr = 16'h0300; s.uses_rs = 1; s.ctrl = 24'h000002;
        s.pc = 16'h0004; s.wb_en = 1; s.wb_reg = 3; s.wb_data = 16'hBEEF;
        apply(s, 1'b0);
        s = idle(); s.if_valid = 1; s.instr = 16'h0360; s.uses_rs = 1; s.uses_rt = 1;
        s.ctrl = 24'h000002; s.pc = 16'h0006;
        apply(s, 1'b0);

        // Load-use: LD R2, then a reader of Rt=2 (held two cycles) while wb fills R2
        s = idle(); s.if_valid = 1; s.instr = 16'h8100; s.ctrl = 24'h000003; s.dst = 2;
        s.uses_rs = 1; s.pc = 16'h0008;
        apply(s, 1'b0);
        s = idle(); s.if_valid = 1; s.instr = 16'h1040; s.uses_rt = 1; s.ctrl = 24'h000002;
        s.dst = 4; s.pc = 16'h000A; s.wb_en = 1; s.wb_reg = 2; s.wb_data = 16'h1234;
        apply(s, 1'b0);
        s.wb_en = 0;
        apply(s, 1'b0);

        // Same hazard under a redirect: no stall, EX killed
        s = idle(); s.if_valid = 1; s.instr = 16'h8100; s.ctrl = 24'h000003; s.dst = 2;
        s.pc = 16'h000C;
        apply(s, 1'b0);
        s = idle(); s.if_valid = 1; s.instr = 16'h1040; s.uses_rt = 1; s.ctrl = 24'h000002;
        s.flush = 1; s.pc = 16'h000E;
        apply(s, 1'b0);

        // Downstream stall for three cycles with changing inputs, then release
        for (int k = 0; k < 4; k++) begin
            s = idle(); s.if_valid = 1; s.instr = 16'(16'h2000 + k * 16'h0123);
            s.ctrl = 24'(24'h000010 + k); s.dst = 3'(k); s.pc = 16'(16'h0100 + 2 * k);
            s.uses_rs = 1; s.stall_in = (k < 3);
            apply(s, 1'b0);
        end

        // Illegal instruction for one cycle: err sticks until reset
        s = idle(); s.if_valid = 1; s.ctrl_err = 1; s.ctrl = 24'h000002; s.pc = 16'h0200;
        apply(s, 1'b0);
        s = idle();
        apply(s, 1'b0);
        apply(s, 1'b0);
        s.rst = 1;
        apply(s, 1'b0);
        s = idle();
        apply(s, 1'b0);

        // Randomised traffic including mid-operation resets, flushes and stalls
        for (int n = 0; n < 600; n++) begin
            s.rst      = ($urandom_range(0, 63) == 0);
            s.if_valid = ($urandom_range(0, 7) != 0);
            s.instr    = 16'($urandom);
            s.pc       = 16'($urandom);
            s.ctrl     = 24'($urandom);
            if ($urandom_range(0, 2) == 0) s.ctrl[1:0] = 2'b11;
            s.dst      = 3'($urandom);
            s.uses_rs  = 1'($urandom_range(0, 1));
            s.uses_rt  = 1'($urandom_range(0, 1));
            s.ctrl_err = ($urandom_range(0, 31) == 0);
            s.wb_en    = 1'($urandom_range(0, 1));
            s.wb_reg   = 3'($urandom);
            s.wb_data  = 16'($urandom);
            s.flush    = ($urandom_range(0, 7) == 0);
            s.stall_in = ($urandom_range(0, 5) == 0);
            apply(s, 1'b0);
        end

        s = idle();
        apply(s, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
